// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter:
//   uart_tx_state_e : transmitter FSM states
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity-mode encodings for PARITY_MODE
//   clks_per_bit()  : clock cycles per line bit (floored at 2)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // A bit shorter than two clocks cannot be timed by the reloading baud
  // counter, so the divider is floored at 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    int cpb;
    cpb = clk_freq / baud;
    if (cpb < 2) cpb = 2;
    return cpb;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO used as the transmitter's input queue.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset (empties the FIFO)
//   push       : write push_data this cycle (accepted when not full, or when
//                full together with a pop)
//   push_data  : WIDTH-bit word to store
//   pop        : remove the head word this cycle (ignored when empty)
//   pop_data   : current head word (valid when !empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB distinguishes full from empty when the index
  // bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity, STOP_BITS stop bits. Each bit lasts
// CLK_FREQ/BAUD_RATE clocks.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset; aborts any frame, drops queued words
//   tx_data  : word to send, captured when tx_valid && tx_ready
//   tx_valid : tx_data is valid
//   tx_ready : a word is accepted this cycle (0 during reset)
//   tx       : serial line, idles high
//   tx_busy  : a frame is on the line
//   tx_done  : one-cycle pulse after the last stop bit of each frame
// Build option:
//   UART_TX_FIFO_EN : when defined, words are queued in a FIFO_DEPTH-entry
//                     input FIFO (tx_ready = !full) so frames can run
//                     back to back; otherwise tx_ready is high only in IDLE.
// -----------------------------------------------------------------------------
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 19200,
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_W);

  uart_tx_state_e    state, state_n;
  logic [CNT_W-1:0]  baud_cnt, baud_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_q, par_n;
  logic              tx_q, tx_n;
  logic              done_q, done_n;
  logic              bit_end;
  logic              take;
  logic              word_avail;
  logic [DATA_W-1:0] word;

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (^w) ^ (PARITY_MODE == PAR_ODD);
  endfunction

`ifdef UART_TX_FIFO_EN
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (take),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_ready   = rst && !fifo_full;
  assign word_avail = !fifo_empty;
  assign word       = fifo_head;
`else
  // Without a queue the handshake itself is the pending word, and it can
  // only happen in IDLE, so the FSM's take strobe has no consumer.
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic unused_take;

  assign unused_take = take;
  assign tx_ready    = rst && (state == IDLE);
  assign word_avail  = tx_valid && tx_ready;
  assign word        = tx_data;
`endif

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    take    = 1'b0;
    bit_end = (baud_cnt == CNT_W'(CPB - 1));

    // The baud counter reloads at every bit boundary, so every line bit,
    // including the first start bit of a back-to-back frame, is CPB long.
    if (state != IDLE) baud_n = bit_end ? '0 : baud_cnt + CNT_W'(1);

    unique case (state)
      IDLE: begin
        if (word_avail) begin
          take    = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
          shreg_n = word;
          par_n   = parity_of(word);
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shreg[0];
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            bit_n = '0;
            if (PARITY_MODE == PAR_NONE) begin
              state_n = STOP;
              tx_n    = 1'b1;
            end else begin
              state_n = PARITY;
              tx_n    = par_q;
            end
          end else begin
            // shreg[0] is the bit on the line; the next one is shreg[1].
            bit_n   = bit_cnt + BIT_W'(1);
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
          bit_n   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            done_n = 1'b1;
            bit_n  = '0;
            if (word_avail) begin
              take    = 1'b1;
              state_n = START;
              tx_n    = 1'b0;
              shreg_n = word;
              par_n   = parity_of(word);
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
    par_q <= par_n;
  end

  assign tx      = tx_q;
  assign tx_busy = (state != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Two transmitters at 16 clocks per bit: dut_a (8 bits, even parity, 1 stop)
// and dut_b (8 bits, odd parity, 2 stops). Expected line frames are pushed
// into per-DUT queues when words are sent; monitors decode the serial line
// and compare each frame against the queue head.
// Frame vectors: bit i = i-th bit on the line (bit 0 = start bit).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_param;

`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NB_A = 11;
  localparam int NB_B = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_ready, a_tx, a_busy, a_done;
  logic       b_valid, b_ready, b_tx, b_busy, b_done;

  int checks = 0;
  int errors = 0;
  int frames_a = 0;
  int frames_b = 0;
  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_b[$];

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_W(8), .PARITY_MODE(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done));

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_W(8), .PARITY_MODE(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor for dut_a: sample each bit mid-way, flag edges off a bit boundary.
  initial begin : mon_a
    int cnt; int glitch; logic [11:0] bits; logic prev; logic act; logic [11:0] e;
    act = 0; cnt = 0; glitch = 0; bits = '0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) act = 0;
      else if (!act) begin
        if (a_tx == 1'b0) begin act = 1; cnt = 0; glitch = 0; bits = '0; end
      end else cnt++;
      if (act) begin
        if (a_tx !== prev && (cnt % 16) != 0) glitch++;
        if ((cnt % 16) == 8) bits[cnt/16] = a_tx;
        if (cnt == 16*NB_A - 8) begin
          act = 0;
          frames_a++;
          if (exp_q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_frame: got %h, required no frame", bits);
          end else begin
            e = exp_q_a.pop_front();
            chk("a_frame", bits, e);
            chk("a_bit_timing", glitch, 0);
          end
        end
      end
      prev = a_tx;
    end
  end

  initial begin : mon_b
    int cnt; int glitch; logic [11:0] bits; logic prev; logic act; logic [11:0] e;
    act = 0; cnt = 0; glitch = 0; bits = '0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) act = 0;
      else if (!act) begin
        if (b_tx == 1'b0) begin act = 1; cnt = 0; glitch = 0; bits = '0; end
      end else cnt++;
      if (act) begin
        if (b_tx !== prev && (cnt % 16) != 0) glitch++;
        if ((cnt % 16) == 8) bits[cnt/16] = b_tx;
        if (cnt == 16*NB_B - 8) begin
          act = 0;
          frames_b++;
          if (exp_q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_frame: got %h, required no frame", bits);
          end else begin
            e = exp_q_b.pop_front();
            chk("b_frame", bits, e);
            chk("b_bit_timing", glitch, 0);
          end
        end
      end
      prev = b_tx;
    end
  end

  // Returns at the first negedge after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic [11:0] e);
    int n = 0;
    @(negedge clk);
    while (!a_ready && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL send_a_timeout: ready stayed %b, required 1", a_ready);
    end
    a_data = d; a_valid = 1'b1; exp_q_a.push_back(e);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; a_data = ~d;
  endtask

  task automatic send_b(input logic [7:0] d, input logic [11:0] e);
    int n = 0;
    @(negedge clk);
    while (!b_ready && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL send_b_timeout: ready stayed %b, required 1", b_ready);
    end
    b_data = d; b_valid = 1'b1; exp_q_b.push_back(e);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0; b_data = ~d;
  endtask

  task automatic wait_idle_a();
    int quiet = 0; int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk); n++;
      if (a_busy) quiet = 0; else quiet++;
    end
    if (quiet < 4) begin
      checks++; errors++;
      $display("FAIL wait_idle_a: busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic wait_idle_b();
    int quiet = 0; int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk); n++;
      if (b_busy) quiet = 0; else quiet++;
    end
    if (quiet < 4) begin
      checks++; errors++;
      $display("FAIL wait_idle_b: busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int done_at, ndone, cnt, f0, first_s, last_d;
    logic [7:0] v;
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_a", a_tx, 1);
    chk("reset_busy_a", a_busy, 0);
    chk("reset_done_a", a_done, 0);
    chk("reset_ready_a", a_ready, 0);
    chk("reset_tx_b", b_tx, 1);
    chk("reset_ready_b", b_ready, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", a_ready, 1);

    // 0xA5, even parity: 0,1,0,1,0,0,1,0,1,0,1
    send_a(8'hA5, 12'h54A);
    done_at = -1; ndone = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == LAT - 1) chk("start_latency", a_tx, 0);
      if (a_done) begin ndone++; if (done_at < 0) done_at = i; end
      @(negedge clk);
    end
    chk("done_cycle", done_at, 175 + LAT);
    chk("done_width", ndone, 1);

    f0 = frames_a;
    send_a(8'h00, 12'h400);
    send_a(8'hFF, 12'h5FE);
    send_a(8'h01, 12'h602);
    send_a(8'h80, 12'h700);
    wait_idle_a();
    chk("frames_a_patterns", frames_a, f0 + 4);

    // Odd parity, two stops: 0x00 -> parity 1, 12 bits of 16 cycles
    send_b(8'h00, 12'hE00);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (b_busy) cnt++;
      @(negedge clk);
    end
    chk("busy_len_b", cnt, 192);
    send_b(8'h07, 12'hC0E);
    wait_idle_b();
    chk("frames_b", frames_b, 2);

`ifdef UART_TX_FIFO_EN
    f0 = frames_a; ndone = 0; first_s = -1; last_d = -1;
    @(negedge clk);
    for (int i = 0; i < 700; i++) begin
      if (i < 3) begin
        chk("fifo_ready_held", a_ready, 1);
        case (i)
          0: begin v = 8'h11; exp_q_a.push_back(12'h422); end
          1: begin v = 8'h22; exp_q_a.push_back(12'h444); end
          default: begin v = 8'h33; exp_q_a.push_back(12'h466); end
        endcase
        a_valid = 1'b1; a_data = v;
      end else begin
        a_valid = 1'b0;
      end
      if (a_tx == 1'b0 && first_s < 0) first_s = i;
      if (a_done) begin ndone++; last_d = i; end
      @(negedge clk);
    end
    chk("fifo_done_pulses", ndone, 3);
    chk("fifo_no_gap_span", last_d - first_s, 528);
    chk("fifo_frames", frames_a, f0 + 3);
`else
    f0 = frames_a;
    send_a(8'h5A, 12'h4B4);
    repeat (40) @(negedge clk);
    chk("ready_low_while_busy", a_ready, 0);
    a_valid = 1'b1; a_data = 8'h33;
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle_a();
    repeat (20) @(negedge clk);
    chk("single_frame_sent", frames_a, f0 + 1);
`endif

    // Reset in the middle of the data bits
    send_a(8'h3C, 12'h478);
    repeat (48) @(negedge clk);
    chk("busy_before_reset", a_busy, 1);
    rst = 1'b0;
    exp_q_a.delete();
    @(posedge clk); #1;
    chk("tx_after_reset", a_tx, 1);
    chk("busy_after_reset", a_busy, 0);
    chk("ready_in_reset", a_ready, 0);
    @(negedge clk); rst = 1'b1;
    f0 = frames_a; cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_tx == 1'b0 || a_busy) cnt++;
      @(negedge clk);
    end
    chk("no_residual_activity", cnt, 0);
    chk("no_residual_frame", frames_a, f0);

    chk("queue_a_drained", exp_q_a.size(), 0);
    chk("queue_b_drained", exp_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 19200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, at least 2).
REQ-003 Parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-004 Parameter PARITY_MODE, default 1, 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 8, power of two, used only with UART_TX_FIFO_EN.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 tx_data  in  DATA_W  word to transmit.
REQ-010 tx_valid  in  1  tx_data is valid.
REQ-011 tx_ready  out  1  block accepts a word this cycle.
REQ-012 tx  out  1  serial line; idle level is 1.
REQ-013 tx_busy  out  1  a frame is on the line.
REQ-014 tx_done  out  1  one-cycle pulse after the last stop bit completes.

Function
REQ-015 The block SHALL accept a word on the rising edge where tx_valid and tx_ready are both 1, and SHALL ignore tx_valid when tx_ready is 0.
REQ-016 The block SHALL capture tx_data at acceptance and SHALL ignore later changes on tx_data for that frame.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with these transitions:
- IDLE->START on a pending word.
- START->DATA.
- DATA->PARITY after DATA_W bits, or DATA->STOP when PARITY_MODE=0.
- PARITY->STOP.
- STOP->START if a word is pending, else STOP->IDLE.
REQ-018 Each line bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-019 The frame SHALL be: start bit 0, data bits LSB first, parity bit (even: XOR of the data; odd: its inverse) if enabled, then STOP_BITS stop bits of 1.
REQ-020 Without the FIFO, tx_ready SHALL equal (state==IDLE).
REQ-021 The start bit SHALL appear on tx in the cycle after acceptance, giving one cycle of latency.
REQ-022 tx_busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-023 tx_done SHALL pulse high for one cycle on the final STOP-bit boundary, including back-to-back frames.
REQ-024 Back-to-back: when a word is pending at the end of STOP, the next start bit SHALL follow with zero idle cycles.
REQ-025 tx SHALL be 1 in IDLE and SHALL never be high-impedance.

Reset
REQ-026 With rst=0 at a rising edge, the block SHALL enter IDLE and SHALL set tx=1, tx_busy=0, tx_done=0, baud counter=0, bit counter=0 and FIFO empty.
REQ-027 Reset mid-frame SHALL abort the frame immediately (the line returns to 1 on that edge) and SHALL discard all pending words.
REQ-028 tx_ready SHALL be 0 while rst=0.

Configuration
REQ-029 The macro UART_TX_FIFO_EN SHALL control the input FIFO.
- Defined: a FIFO_DEPTH-entry input FIFO is included; tx_ready = !full; FIFO push and FSM pop in the same cycle are both legal when full or empty; the FSM takes words from the FIFO head.
- Not defined: no FIFO is built; the behaviour of REQ-020 applies.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum uart_tx_state_e, the parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD, and the function clks_per_bit(clk_freq, baud).
REQ-031 The FIFO SHALL be the single sub-module uart_sync_fifo (parameters WIDTH and DEPTH), instantiated only under UART_TX_FIFO_EN.

Verification
REQ-032 With CLK_FREQ=16, BAUD_RATE=1, DATA_W=8 and even parity, sending 0xA5 SHALL produce the sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 16 cycles, and tx_done SHALL pulse at cycle 176 after acceptance.
REQ-033 With odd parity and 2 stop bits, sending 0x00 SHALL produce parity bit 1, two stop bits of 1 (32 cycles), and tx_busy high for 192 cycles.
REQ-034 With the FIFO enabled, pushing 0x11, 0x22 and 0x33 on consecutive cycles SHALL produce three frames with no idle gap, tx_ready held at 1, and three tx_done pulses.
REQ-035 Asserting rst=0 in the middle of the DATA state SHALL give tx=1 and tx_busy=0 on the next edge, and after release SHALL send no residual frame.
REQ-036 With the FIFO disabled, pulsing tx_valid while tx_busy=1 SHALL leave the word unaccepted, so that exactly one frame is sent.
